// File: rtl/mod_invreg16_ctrl_if.sv
// rtl/mod_invreg16_ctrl_if.sv - ciphertext/plaintext handshakes and round-logic bus of the AES-256 decrypt state register
interface mod_invreg16_ctrl_if #(
    parameter int N = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][7:0]   inp_cipher;
    logic [N-1:0][7:0]   inp_rkey;
    logic                key_valid;
    logic [N-1:0][7:0]   inp_invmC;
    logic [N-1:0][7:0]   inp_ark;
    logic [N-1:0][7:0]   outp_state;
    logic [3:0]          outp_round;
    logic                busy;
    logic                out_valid;
    logic                out_ready;

    // master is the surrounding datapath/producer/consumer, slave is the controller
    modport master (
        output in_valid, inp_cipher, inp_rkey, key_valid, inp_invmC, inp_ark, out_ready,
        input  in_ready, outp_state, outp_round, busy, out_valid
    );

    modport slave (
        input  in_valid, inp_cipher, inp_rkey, key_valid, inp_invmC, inp_ark, out_ready,
        output in_ready, outp_state, outp_round, busy, out_valid
    );
endinterface

// File: rtl/mod_invreg16_ctrl.sv
// rtl/mod_invreg16_ctrl.sv - AES-256 decryption state register and inverse round sequencer
module mod_invreg16_ctrl #(
    parameter int N  = 16,
    parameter int NR = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    mod_invreg16_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [N-1:0][7:0] state_q;
    logic [N-1:0][7:0] state_d;
    logic [3:0]        round_q;
    logic [3:0]        round_d;
    logic              in_ready;
    logic              busy;
    logic              out_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                round_d  = 4'd0;
                // Initial whitening needs the round key, so acceptance waits for key_valid
                if (bus.in_valid && bus.key_valid) begin
                    state_d = bus.inp_cipher ^ bus.inp_rkey;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bus.key_valid) begin
                    if (round_q >= LAST_ROUND) begin
                        state_d = bus.inp_ark;
                        round_d = LAST_ROUND;
                        fsm_d   = DONE;
                    end else begin
                        state_d = bus.inp_invmC;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.out_valid  = out_valid;
    assign bus.outp_state = state_q;
    assign bus.outp_round = round_q;

endmodule

// File: tb/tb_mod_invreg16_ctrl.sv
// tb/tb_mod_invreg16_ctrl.sv - self-checking bench for mod_invreg16_ctrl
module tb_mod_invreg16_ctrl;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    logic [127:0] sb[$];

    mod_invreg16_ctrl_if #(.N(16)) bus ();

    mod_invreg16_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Round-logic stubs
    assign bus.inp_invmC = bus.outp_state ^ {16{8'h01}};
    assign bus.inp_ark   = bus.outp_state ^ {16{8'hFF}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] s;
        s = c ^ k;
        for (int r = 1; r <= 13; r++) s = s ^ 8'h01;
        return s ^ 8'hFF;
    endfunction

    task automatic run_block(input logic [7:0] c, input logic [7:0] k, input int stall_round,
                             input int stall_n, input int bp_n, input int abort_round);
        logic [127:0] hold;
        logic [127:0] exp;
        int edges;
        int exp_round;
        int guard;
        int stall_left;
        bit exp_done;
        stall_left = stall_n;
        bus.inp_rkey   = {16{k}};
        bus.inp_cipher = {16{c}};
        bus.in_valid   = 1'b1;
        bus.key_valid  = 1'b1;
        bus.out_ready  = (bp_n == 0);
        chk("in_ready_idle", bus.in_ready, 1);
        sb.push_back({16{model(c, k)}});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 1;
        exp_round = 1;
        exp_done = 0;
        chk("white_state", bus.outp_state, {16{c ^ k}});
        chk("accept_round", bus.outp_round, 1);
        chk("accept_busy", bus.busy, 1);
        chk("accept_in_ready", bus.in_ready, 0);
        guard = 0;
        while (!exp_done && guard < 60) begin
            guard++;
            if (abort_round != 0 && exp_round == abort_round) begin
                resetn = 1'b0;
                #1;
                chk("abort_state", bus.outp_state, 0);
                chk("abort_round", bus.outp_round, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_out_valid", bus.out_valid, 0);
                chk("abort_in_ready", bus.in_ready, 1);
                void'(sb.pop_back());
                @(posedge clk); #1;
                resetn = 1'b1;
                return;
            end
            if (stall_left > 0 && exp_round == stall_round) begin
                hold = bus.outp_state;
                bus.key_valid = 1'b0;
                for (int i = 0; i < stall_left; i++) begin
                    @(posedge clk); #1;
                    edges++;
                    chk("stall_round", bus.outp_round, exp_round);
                    chk("stall_state", bus.outp_state, hold);
                    chk("stall_busy", bus.busy, 1);
                end
                bus.key_valid = 1'b1;
                stall_left = 0;
            end
            @(posedge clk); #1;
            edges++;
            if (exp_round == 14) exp_done = 1;
            else exp_round++;
            chk("round_step", bus.outp_round, exp_round);
            chk("out_valid_step", bus.out_valid, exp_done);
        end
        chk("run_timeout", guard < 60, 1);
        chk("latency", edges, 15 + stall_n);
        chk("done_in_ready", bus.in_ready, 0);
        chk("done_busy", bus.busy, 0);
        if (bp_n > 0) begin
            hold = bus.outp_state;
            bus.in_valid   = 1'b1;
            bus.inp_cipher = {16{8'h55}};
            for (int i = 0; i < bp_n; i++) begin
                @(posedge clk); #1;
                chk("bp_out_valid", bus.out_valid, 1);
                chk("bp_state", bus.outp_state, hold);
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_busy", bus.busy, 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            exp = sb.pop_front();
            chk("plaintext", bus.outp_state, exp);
        end
        @(posedge clk); #1;
        chk("post_out_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
        chk("post_round", bus.outp_round, 0);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.inp_cipher = '0;
        bus.inp_rkey   = '0;
        bus.key_valid  = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_state", bus.outp_state, 0);
        chk("rst_round", bus.outp_round, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);

        // in_valid without key_valid must not be accepted
        bus.in_valid = 1'b1;
        bus.inp_cipher = {16{8'h33}};
        @(posedge clk); #1;
        chk("nokey_busy", bus.busy, 0);
        chk("nokey_state", bus.outp_state, 0);
        chk("nokey_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;

        run_block(8'h00, 8'h00, 0, 0, 0, 0);
        run_block(8'h00, 8'h00, 7, 3, 0, 0);
        run_block(8'h00, 8'h00, 0, 0, 5, 0);
        run_block(8'h55, 8'h00, 0, 0, 0, 0);
        run_block(8'hA0, 8'h0F, 0, 0, 0, 0);
        run_block(8'h00, 8'h00, 0, 0, 0, 9);
        run_block(8'h00, 8'h00, 0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_invreg16_ctrl.md
Name: mod_invreg16_ctrl

Overview:
- 16-byte state register plus round sequencer for the AES-256 decryption datapath.
- Accepts a ciphertext block through a valid/ready handshake and applies the initial AddRoundKey whitening itself.
- Steps 14 inverse rounds, one per key-valid cycle:
  - rounds 1..13 capture the InvMixColumns result;
  - round 14 captures the final AddRoundKey result.
- Presents the plaintext through a valid/ready output handshake.
- Drives the round index consumed by the key schedule and the inverse round logic.

Parameters:
N, 16, number of state bytes (fixed for AES; not to be overridden)
NR, 14, number of rounds (AES-256)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext block offered
in_ready  output  1  block can accept a ciphertext (combinational, high iff FSM in IDLE)
inp_cipher  input  [N-1:0][7:0]  ciphertext bytes, byte 0 first
inp_rkey  input  [N-1:0][7:0]  round key for the current outp_round (the key schedule supplies K[14-round])
key_valid  input  1  inp_rkey valid this cycle; round advance stalls while low
inp_invmC  input  [N-1:0][7:0]  InvShiftRows→InvSubBytes→AddRoundKey→InvMixColumns of outp_state
inp_ark  input  [N-1:0][7:0]  InvShiftRows→InvSubBytes→AddRoundKey of outp_state (final round)
outp_state  output  [N-1:0][7:0]  registered state, feeds the inverse round logic
outp_round  output  [3:0]  current round index 0..14
busy  output  1  high in RUN
out_valid  output  1  plaintext on outp_state valid
out_ready  input  1  consumer accepts plaintext

Behaviour:
- Reset (resetn low, asynchronous, any state including mid-block):
  - FSM→IDLE; outp_state=all 0x00; outp_round=0; busy=0; out_valid=0; in_ready=1 once FSM is IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - outp_round=0.
  - On in_valid & in_ready & key_valid: outp_state<=inp_cipher ^ inp_rkey (bytewise), outp_round<=1, →RUN.
  - If in_valid while key_valid=0: no accept, in_ready remains high, bench retries; nothing is captured.
- RUN, key_valid=1:
  - Round 1..13: outp_state<=inp_invmC, outp_round<=outp_round+1.
  - Round 14: outp_state<=inp_ark, →DONE; outp_round holds 14.
- RUN, key_valid=0: outp_state and outp_round hold (stall); busy stays 1.
- DONE:
  - out_valid=1, outp_state holds the plaintext unchanged until handshake.
  - On out_ready: →IDLE, outp_round<=0, out_valid falls the next cycle.
  - in_ready=0 in DONE; no overlap of accept and deliver.
- Latency: with key_valid held high, 15 rising edges from accept edge to out_valid high (1 whitening + 14 rounds). Each stall cycle adds one.
- outp_round never exceeds 14 and never wraps; any illegal FSM encoding recovers to IDLE.
- in_valid/inp_cipher are ignored outside IDLE; inp_invmC/inp_ark are ignored outside RUN.
- out_ready outside DONE has no effect.

Test Plan:
Bench stubs for all scenarios: inp_rkey=0x00 all bytes; inp_invmC=outp_state^0x01 per byte; inp_ark=outp_state^0xFF per byte.
1. Reset then idle: resetn low 3 cycles, release → outp_state=0, outp_round=0, in_ready=1, busy=0, out_valid=0.
2. Single block, cipher all 0x00, key_valid=1, out_ready=1:
   - outp_round steps 1..14;
   - out_valid rises 15 edges after accept with outp_state all 0xFE;
   - IDLE one cycle later.
3. Stall: as 2, but key_valid=0 for 3 cycles at round 7 → outp_round and outp_state frozen; out_valid at 18 edges; same result 0xFE.
4. Backpressure:
   - out_ready=0 for 5 cycles in DONE → out_valid and outp_state 0xFE hold, in_ready=0;
   - a concurrent in_valid with cipher 0x55 is not accepted;
   - after out_ready, the next block 0x55 yields 0xAB.
5. Whitening: inp_rkey=0x0F while IDLE, cipher 0xA0 → after accept edge outp_state=0xAF.
6. Reset mid-operation at round 9 → immediately outp_state=0, outp_round=0, busy=0; a fresh block 0x00 then completes normally to 0xFE.
